// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port and the data access port over a req/ack handshake, and raises
// mem_stall while any requester is still waiting for its access to complete.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [3:0]      dm_amp,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_amp,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            mem_stall
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              first_q, first_d;        // first cycle of a BUSY state: ack ignored
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_amp_q, mem_amp_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;

  logic grant_i;
  logic grant_d;
  logic retire;
  logic arb_ok;

  // A retiring requester still shows its req in the valid cycle, so no grant
  // is decided until the cycle after a valid pulse.
  assign arb_ok = ~(if_valid_q | dm_valid_q);

  // Next-state: arbitrate in IDLE, retire the access on an eligible ack.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_ok) begin
          // Data wins unless fetch has already waited LIMIT data grants.
          if (dm_req && !(if_req && starve_cnt_q == LIMIT)) begin
            grant_d = 1'b1;
            state_d = BUSY_D;
          end else if (if_req) begin
            grant_i = 1'b1;
            state_d = BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack && !first_q) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: load the memory request at the grant edge,
  // hold it until the ack, then pulse the matching valid and capture rdata.
  always_comb begin
    first_d      = 1'b0;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_amp_d    = mem_amp_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_valid_d   = 1'b0;
    dm_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    if (grant_d) begin
      first_d     = 1'b1;
      mem_req_d   = 1'b1;
      mem_we_d    = dm_we;
      mem_amp_d   = dm_amp;
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
      if (if_req && starve_cnt_q != 4'hF) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end

    if (grant_i) begin
      first_d      = 1'b1;
      mem_req_d    = 1'b1;
      mem_we_d     = 1'b0;
      mem_amp_d    = 4'b0000;
      mem_addr_d   = if_addr;
      starve_cnt_d = 4'd0;
    end

    if (retire) begin
      mem_req_d = 1'b0;
      if (state_q == BUSY_I) begin
        if_valid_d = 1'b1;
        if_rdata_d = mem_rdata;
      end else begin
        dm_valid_d = 1'b1;
        dm_rdata_d = mem_rdata;
      end
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q      <= IDLE;
      first_q      <= 1'b0;
      starve_cnt_q <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_amp_q    <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_amp_q    <= mem_amp_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_valid_q   <= if_valid_d;
      dm_valid_q   <= dm_valid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_amp   = mem_amp_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  // Stall drops in the same cycle the valid pulse retires the last request.
  assign mem_stall = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_valid;
  logic            dm_req;
  logic            dm_we;
  logic [3:0]      dm_amp;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic [XLEN-1:0] dm_rdata;
  logic            dm_valid;
  logic            mem_req;
  logic            mem_we;
  logic [3:0]      mem_amp;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;
  logic            mem_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_amp(dm_amp), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_amp(mem_amp), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_stall(mem_stall)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the memory, how long, and fetch's wait count.
  int              m_owner  = 0;   // 0 none, 1 fetch, 2 data
  int              m_age    = 0;   // completed cycles in the current access
  int              m_starve = 0;   // data grants taken while fetch waited
  bit              m_rst    = 1'b0;
  logic            e_mem_req = 1'b0, e_we = 1'b0;
  logic [3:0]      e_amp = '0;
  logic [XLEN-1:0] e_addr = '0, e_wdata = '0, e_if_rdata = '0, e_dm_rdata = '0;
  logic            e_if_valid = 1'b0, e_dm_valid = 1'b0;

  // Memory responder and grant log.
  bit              auto_mem  = 1'b0;
  bit              rand_data = 1'b0;
  int              lat_lo = 2, lat_hi = 2, cur_lat = 2, req_age = 0;
  logic [XLEN-1:0] fixed_rdata = '0;
  logic            prev_mem_req = 1'b0;
  bit              grant_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one clock edge's worth of the arbiter's rules to the model.
  task automatic model_edge();
    bit was_valid;
    bit fetch_wins;
    if (!reset) begin
      m_owner = 0; m_age = 0; m_starve = 0; m_rst = 1'b1;
      e_mem_req = 1'b0; e_we = 1'b0; e_amp = '0; e_addr = '0; e_wdata = '0;
      e_if_valid = 1'b0; e_dm_valid = 1'b0; e_if_rdata = '0; e_dm_rdata = '0;
      return;
    end
    m_rst      = 1'b0;
    was_valid  = e_if_valid | e_dm_valid;
    e_if_valid = 1'b0;
    e_dm_valid = 1'b0;
    if (m_owner == 0) begin
      if (!was_valid) begin
        fetch_wins = if_req && (!dm_req || m_starve == LIMIT);
        if (fetch_wins) begin
          m_owner = 1; m_age = 0; m_starve = 0;
          e_mem_req = 1'b1; e_we = 1'b0; e_amp = 4'b0000; e_addr = if_addr;
        end else if (dm_req) begin
          m_owner = 2; m_age = 0;
          if (if_req && m_starve < 15) m_starve++;
          e_mem_req = 1'b1; e_we = dm_we; e_amp = dm_amp;
          e_addr = dm_addr; e_wdata = dm_wdata;
        end
      end
    end else if (mem_ack && m_age >= 1) begin
      e_mem_req = 1'b0;
      if (m_owner == 1) begin
        e_if_valid = 1'b1; e_if_rdata = mem_rdata;
      end else begin
        e_dm_valid = 1'b1; e_dm_rdata = mem_rdata;
      end
      m_owner = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_outputs();
    check1("mem_req", mem_req, e_mem_req);
    check1("if_valid", if_valid, e_if_valid);
    check1("dm_valid", dm_valid, e_dm_valid);
    check("if_rdata", if_rdata, e_if_rdata);
    check("dm_rdata", dm_rdata, e_dm_rdata);
    check1("mem_stall", mem_stall, (if_req & ~e_if_valid) | (dm_req & ~e_dm_valid));
    if (e_mem_req || m_rst) begin
      check("mem_addr", mem_addr, e_addr);
      check1("mem_we", mem_we, e_we);
      check("mem_amp", 32'(mem_amp), 32'(e_amp));
    end
    if ((e_mem_req && m_owner == 2) || m_rst) check("mem_wdata", mem_wdata, e_wdata);
  endtask

  task automatic mem_respond();
    if (mem_req) begin
      if (req_age == 0) cur_lat = int'($urandom_range(lat_hi, lat_lo));
      req_age++;
      mem_ack = (req_age == cur_lat);
      if (mem_ack) mem_rdata = rand_data ? XLEN'($urandom) : fixed_rdata;
    end else begin
      req_age = 0;
      mem_ack = 1'b0;
    end
  endtask

  // One clock: model at the rising edge, compare and respond at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (mem_req && !prev_mem_req) grant_log.push_back(mem_addr == if_addr);
    prev_mem_req = mem_req;
    if (auto_mem) mem_respond();
  endtask

  task automatic wait_valid(input bit fetch, input string tag, output int n);
    n = 0;
    while (!(fetch ? if_valid : dm_valid) && n < 60) begin
      cycle();
      n++;
    end
    check1(tag, fetch ? if_valid : dm_valid, 1'b1);
  endtask

  initial begin
    int  n;
    bit  saw_dm_valid;

    // Reset held with a fetch pending and a stray ack.
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h0000_1000;
    dm_req = 1'b0; dm_we = 1'b0; dm_amp = '0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    repeat (2) cycle();
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_if_valid", if_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);

    // Release: grant one edge later; ack still high in IDLE and first BUSY cycle.
    reset = 1'b1;
    cycle();
    check1("rel_mem_req", mem_req, 1'b1);
    check("rel_mem_addr", mem_addr, 32'h0000_1000);
    cycle();
    check1("first_busy_ack_ignored", if_valid, 1'b0);
    mem_ack = 1'b0; auto_mem = 1'b1; req_age = 1; cur_lat = 2; rand_data = 1'b1;
    wait_valid(1'b1, "rel_fetch_done", n);
    if_req = 1'b0;
    cycle();

    // Single fetch with a minimum-latency memory.
    rand_data = 1'b0; fixed_rdata = 32'h0050_0093; lat_lo = 2; lat_hi = 2;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    wait_valid(1'b1, "fetch_valid", n);
    check("fetch_latency", 32'(n), 32'd3);
    check("fetch_rdata", if_rdata, 32'h0050_0093);
    if_req = 1'b0;
    cycle();
    check1("fetch_pulse_one_cycle", if_valid, 1'b0);

    // Store.
    fixed_rdata = 32'hCAFE_0001; lat_lo = 3; lat_hi = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0104;
    dm_wdata = 32'hDEAD_BEEF; dm_amp = 4'b0011;
    wait_valid(1'b0, "store_valid", n);
    check("store_latency", 32'(n), 32'd4);
    dm_req = 1'b0;
    cycle();

    // Simultaneous: data first, then fetch.
    rand_data = 1'b1; lat_lo = 2; lat_hi = 4;
    grant_log.delete();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    dm_req = 1'b1; dm_we = 1'b1; dm_amp = 4'b1111;
    dm_addr = 32'h8000_0200; dm_wdata = 32'h0BAD_F00D;
    wait_valid(1'b0, "simul_dm_valid", n);
    dm_req = 1'b0;
    wait_valid(1'b1, "simul_if_valid", n);
    if_req = 1'b0;
    cycle();
    check("simul_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check1("simul_first_is_data", grant_log[0], 1'b0);
      check1("simul_second_is_fetch", grant_log[1], 1'b1);
    end

    // Starvation: LIMIT data grants, then fetch is forced.
    grant_log.delete();
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    for (int k = 0; k < LIMIT; k++) wait_valid(1'b0, "starve_dm_valid", n);
    wait_valid(1'b1, "starve_if_valid", n);
    if_req = 1'b0; dm_req = 1'b0;
    cycle();
    check("starve_grants", 32'(grant_log.size()), 32'(LIMIT + 1));
    for (int k = 0; k < grant_log.size(); k++)
      check1("starve_grant_side", grant_log[k], k == LIMIT);
    check("starve_cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);

    // Reset in the second BUSY_D cycle, ack one cycle after release.
    auto_mem = 1'b0; mem_ack = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
    cycle();
    cycle();
    check1("mid_busy", mem_req, 1'b1);
    reset = 1'b0; dm_req = 1'b0;
    saw_dm_valid = 1'b0;
    cycle();
    saw_dm_valid |= dm_valid;
    check1("mid_rst_mem_req", mem_req, 1'b0);
    reset = 1'b1;
    cycle();
    saw_dm_valid |= dm_valid;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    cycle();
    saw_dm_valid |= dm_valid;
    mem_ack = 1'b0;
    cycle();
    saw_dm_valid |= dm_valid;
    check1("mid_rst_no_valid", saw_dm_valid, 1'b0);
    check1("mid_rst_idle", mem_req, 1'b0);

    // Randomized traffic with occasional resets.
    auto_mem = 1'b1; rand_data = 1'b1; lat_lo = 2; lat_hi = 5; req_age = 0;
    for (int it = 0; it < 1500; it++) begin
      cycle();
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(199, 0) == 0) begin
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
      end else begin
        if (if_valid) if_req = 1'b0;
        else if (!if_req && $urandom_range(1, 0) == 1) begin
          if_req = 1'b1; if_addr = XLEN'($urandom) & 32'hFFFF_FFFC;
        end
        if (dm_valid) dm_req = 1'b0;
        else if (!dm_req && $urandom_range(1, 0) == 1) begin
          dm_req = 1'b1; dm_we = 1'($urandom); dm_amp = 4'($urandom);
          dm_addr = XLEN'($urandom); dm_wdata = XLEN'($urandom);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
